// File: rtl/mem_issue_queue_if.sv
// Bundles the dispatch, writeback broadcast and issue buses of the memory issue queue.
// Both handshakes transfer on a cycle where the valid and its ready/allowin are high together; valid never waits on ready.
interface mem_issue_queue_if #(
    parameter int TAG_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [TAG_W-1:0]      in_rob_id;
    logic [5:0]            in_uop;
    logic [31:0]           in_imm;
    logic [TAG_W-1:0]      in_rs1_tag;
    logic [TAG_W-1:0]      in_rs2_tag;
    logic                  in_rs1_ready;
    logic                  in_rs2_ready;
    logic [31:0]           in_rs1_data;
    logic [31:0]           in_rs2_data;

    logic [1:0]            wb_valid;
    logic [1:0][TAG_W-1:0] wb_tag;
    logic [1:0][31:0]      wb_data;

    logic                  out_valid;
    logic                  out_allowin;
    logic [TAG_W-1:0]      out_rob_id;
    logic [5:0]            out_uop;
    logic [31:0]           out_imm;
    logic [31:0]           out_rs1_data;
    logic [31:0]           out_rs2_data;

    modport master (
        output in_valid, in_rob_id, in_uop, in_imm, in_rs1_tag, in_rs2_tag,
        output in_rs1_ready, in_rs2_ready, in_rs1_data, in_rs2_data,
        output wb_valid, wb_tag, wb_data, out_allowin,
        input  in_ready, out_valid, out_rob_id, out_uop, out_imm, out_rs1_data, out_rs2_data
    );

    modport slave (
        input  in_valid, in_rob_id, in_uop, in_imm, in_rs1_tag, in_rs2_tag,
        input  in_rs1_ready, in_rs2_ready, in_rs1_data, in_rs2_data,
        input  wb_valid, wb_tag, wb_data, out_allowin,
        output in_ready, out_valid, out_rob_id, out_uop, out_imm, out_rs1_data, out_rs2_data
    );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: circular buffer whose entries wake up on writeback broadcasts
// and issue strictly from the head once both operands are ready.
module mem_issue_queue #(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 5,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    mem_issue_queue_if.slave bus,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] rs1_rdy;
    logic [DEPTH-1:0] rs2_rdy;

    logic [TAG_W-1:0] rob_q      [DEPTH];
    logic [5:0]       uop_q      [DEPTH];
    logic [31:0]      imm_q      [DEPTH];
    logic [TAG_W-1:0] rs1_tag_q  [DEPTH];
    logic [TAG_W-1:0] rs2_tag_q  [DEPTH];
    logic [31:0]      rs1_data_q [DEPTH];
    logic [31:0]      rs2_data_q [DEPTH];

    logic             enq;
    logic             deq;
    logic [32:0]      enq_hit1;
    logic [32:0]      enq_hit2;
    logic             new_rs1_rdy;
    logic             new_rs2_rdy;
    logic [31:0]      new_rs1_data;
    logic [31:0]      new_rs2_data;
    logic [32:0]      rs1_hit [DEPTH];
    logic [32:0]      rs2_hit [DEPTH];
    logic [DEPTH-1:0] rs1_wake;
    logic [DEPTH-1:0] rs2_wake;

    // Returns {hit, data}; port 0 wins when both ports carry the same tag.
    function automatic logic [32:0] wb_lookup(
        input logic [TAG_W-1:0]      tag,
        input logic [1:0]            v,
        input logic [1:0][TAG_W-1:0] t,
        input logic [1:0][31:0]      d
    );
        logic [32:0] r;
        r = '0;
        if (v[0] && t[0] == tag) begin
            r = {1'b1, d[0]};
        end else if (v[1] && t[1] == tag) begin
            r = {1'b1, d[1]};
        end
        return r;
    endfunction

    // in_ready looks only at occupancy, never at a dequeue happening in the same cycle.
    assign bus.in_ready  = rst && !flush && (count < FULL);
    assign bus.out_valid = rst && !flush && (count != '0) && rs1_rdy[head] && rs2_rdy[head];

    assign enq = bus.in_valid && bus.in_ready;
    assign deq = bus.out_valid && bus.out_allowin;

    assign bus.out_rob_id   = rob_q[head];
    assign bus.out_uop      = uop_q[head];
    assign bus.out_imm      = imm_q[head];
    assign bus.out_rs1_data = rs1_data_q[head];
    assign bus.out_rs2_data = rs2_data_q[head];

    assign enq_hit1     = wb_lookup(bus.in_rs1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    assign enq_hit2     = wb_lookup(bus.in_rs2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    assign new_rs1_rdy  = bus.in_rs1_ready || enq_hit1[32];
    assign new_rs2_rdy  = bus.in_rs2_ready || enq_hit2[32];
    assign new_rs1_data = bus.in_rs1_ready ? bus.in_rs1_data : enq_hit1[31:0];
    assign new_rs2_data = bus.in_rs2_ready ? bus.in_rs2_data : enq_hit2[31:0];

    // Only live entries still waiting on an operand may capture a broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit[i]  = wb_lookup(rs1_tag_q[i], bus.wb_valid, bus.wb_tag, bus.wb_data);
            rs2_hit[i]  = wb_lookup(rs2_tag_q[i], bus.wb_valid, bus.wb_tag, bus.wb_data);
            rs1_wake[i] = valid[i] && !rs1_rdy[i] && rs1_hit[i][32];
            rs2_wake[i] = valid[i] && !rs2_rdy[i] && rs2_hit[i][32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (!enq && deq) begin
                count <= count - CNT_W'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (rs1_wake[i]) begin
                    rs1_rdy[i] <= 1'b1;
                end
                if (rs2_wake[i]) begin
                    rs2_rdy[i] <= 1'b1;
                end
            end
            if (deq) begin
                valid[head] <= 1'b0;
            end
            // The tail slot is always free when enq fires, so this never collides with a wakeup.
            if (enq) begin
                valid[tail]   <= 1'b1;
                rs1_rdy[tail] <= new_rs1_rdy;
                rs2_rdy[tail] <= new_rs2_rdy;
            end
        end
    end

    // Payload needs no reset: it is only observed through valid/ready bits that do.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rs1_wake[i]) begin
                rs1_data_q[i] <= rs1_hit[i][31:0];
            end
            if (rs2_wake[i]) begin
                rs2_data_q[i] <= rs2_hit[i][31:0];
            end
        end
        if (enq) begin
            rob_q[tail]      <= bus.in_rob_id;
            uop_q[tail]      <= bus.in_uop;
            imm_q[tail]      <= bus.in_imm;
            rs1_tag_q[tail]  <= bus.in_rs1_tag;
            rs2_tag_q[tail]  <= bus.in_rs2_tag;
            rs1_data_q[tail] <= new_rs1_data;
            rs2_data_q[tail] <= new_rs2_data;
        end
    end
endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TAG_W, default 5: ROB id / operand tag width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  pipeline flush; discards all entries.
REQ-006 in_valid  in  1  dispatch offers one load/store.
REQ-007 in_ready  out  1  queue accepts the offer this cycle.
REQ-008 in_rob_id  in  TAG_W  ROB id of the offered instruction.
REQ-009 in_uop  in  6  memory micro-op; bit5 = store, bits2:0 = width/sign funct.
REQ-010 in_imm  in  32  address offset.
REQ-011 in_rs1_tag, in_rs2_tag  in  TAG_W each  producer tags of base and store-data operands.
REQ-012 in_rs1_ready, in_rs2_ready  in  1 each  operand value already valid.
REQ-013 in_rs1_data, in_rs2_data  in  32 each  operand values, meaningful only when ready.
REQ-014 wb_valid  in  2  per-port writeback broadcast valid.
REQ-015 wb_tag  in  2xTAG_W  per-port result tag.
REQ-016 wb_data  in  2x32  per-port result value.
REQ-017 out_valid  out  1  head entry issued to memory unit.
REQ-018 out_allowin  in  1  memory unit accepts the issue.
REQ-019 out_rob_id, out_uop, out_imm, out_rs1_data, out_rs2_data  out  TAG_W/6/32/32/32  head entry fields.

Function
REQ-020 Storage SHALL be a circular buffer: head pointer, tail pointer, count of 0..DEPTH.
REQ-021 in_ready SHALL be 1 when count < DEPTH and flush = 0; it SHALL NOT depend on same-cycle dequeue.
REQ-022 Enqueue (in_valid && in_ready) SHALL write the entry at tail, advance tail modulo DEPTH, and increment count.
REQ-023 At enqueue, an operand SHALL be marked ready if its in_rsX_ready = 1 or any wb port in that cycle has wb_valid = 1 and wb_tag = in_rsX_tag; a wb match SHALL supply the data.
REQ-024 Each cycle, every valid entry with a not-ready operand SHALL compare its tag with both wb ports; on match it SHALL capture wb_data and become ready at the next edge.
REQ-025 If both wb ports match one operand, port 0 SHALL win.
REQ-026 Issue is strictly in order: out_valid SHALL be count > 0, head rs1 ready, head rs2 ready, and flush = 0; readiness SHALL come only from registered state, with no same-cycle wb bypass.
REQ-027 out_* fields SHALL be driven directly from the head entry; they are don't-care when out_valid = 0.
REQ-028 Dequeue (out_valid && out_allowin) SHALL advance head modulo DEPTH and decrement count.
REQ-029 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-030 A held issue (out_valid = 1, out_allowin = 0) SHALL keep every out_* field stable until accepted or flushed.
REQ-031 Flush SHALL set count, head and tail to 0 at the next edge; enqueue and dequeue SHALL be suppressed that cycle.
REQ-032 Pointer wrap-around SHALL preserve FIFO order across DEPTH boundaries.
REQ-033 Wakeup SHALL NOT modify invalid entries, and stale tags from flushed entries SHALL have no effect.

Reset
REQ-034 While rst = 0: count = 0, head = 0, tail = 0, all entry-valid and ready bits = 0; out_valid = 0 and in_ready = 0.
REQ-035 The first rising edge after rst deasserts SHALL see in_ready = 1.
REQ-036 Reset asserted mid-operation SHALL clear the queue immediately, without waiting for a clock edge.

Verification
REQ-037 Load with rs1 ready (rob 3, rs1 0x1000, imm 4) into empty queue, out_allowin = 1 -> out_valid = 1 next cycle with rob 3, rs1 0x1000, imm 4; count returns to 0.
REQ-038 Store enqueued with rs2 tag 7 not ready; wb port 1 broadcasts tag 7 data 0xDEADBEEF two cycles later -> out_valid rises exactly one cycle after broadcast, with out_rs2_data = 0xDEADBEEF.
REQ-039 Fill 4 entries with out_allowin = 0 -> in_ready = 0 with count 4; release allowin -> 4 issues in enqueue order; in_ready returns to 1 after the first dequeue.
REQ-040 Head waits on rs1 while entry 2 is fully ready -> no issue until head wakes; then head issues, then entry 2.
REQ-041 Queue holding 3 entries, flush = 1 with simultaneous in_valid = 1 -> count = 0 next cycle, nothing enqueued, out_valid = 0; a wb of an old tag afterwards leaves the queue empty.
REQ-042 Run 10 enqueue/dequeue pairs back-to-back at count 2 -> pointers wrap and output order matches input order.
